// File: rtl/prime_pkg.sv
// Shared prime-table definitions: index/value widths used by the prime RAM,
// the populate block and the read-port arbiter, plus the response tag that
// travels alongside an outstanding prime RAM read.
package prime_pkg;

  localparam int unsigned PRIME_ADDR_W = 8;
  localparam int unsigned PRIME_DATA_W = 10;
  // Upper bound on requesters sharing one port; sizes the one-hot tag id.
  localparam int unsigned MAX_REQ      = 8;
  localparam int unsigned GRANT_CNT_W  = 16;

  // One in-flight read: owner (one-hot) and whether its data must be discarded.
  typedef struct packed {
    logic               valid;
    logic [MAX_REQ-1:0] id;
    logic               err;
  } rsp_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: returns a one-hot grant for the first set
// request at or above the pointer, searching upward with wrap-around.
//   req_i   : request vector
//   ptr_i   : highest-priority index this cycle (must be < NUM_REQ)
//   grant_o : one-hot grant, all zero when no request is set
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o
);

  logic [NUM_REQ-1:0]   req_rot;
  logic [NUM_REQ-1:0]   gnt_rot;
  logic [2*NUM_REQ-1:0] gnt_dbl;

  // Rotate so the pointer lands on bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    req_rot = NUM_REQ'({req_i, req_i} >> ptr_i);
    gnt_rot = req_rot & (~req_rot + NUM_REQ'(1));
    gnt_dbl = {NUM_REQ'(0), gnt_rot} << ptr_i;
    grant_o = gnt_dbl[NUM_REQ-1:0] | gnt_dbl[2*NUM_REQ-1:NUM_REQ];
  end

endmodule

// File: rtl/prime_ram_arbiter.sv
// Shares the single read port of the generated-prime RAM between NUM_REQ
// requesters. One round-robin grant per cycle while the prime table is valid;
// each granted index is range-checked against prime_count and the answer is
// returned to its owner, tagged one-hot, RAM_LATENCY cycles later.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   table_valid    : prime table complete; low while calculating/populating
//   prime_count    : number of valid entries in the prime RAM
//   req, req_addr  : per-requester level request and index (slice i = requester i)
//   ack            : one-hot grant pulse in the grant cycle (combinational)
//   rsp_valid      : one-hot response strobe
//   rsp_data       : prime value, zero when no response or on error
//   rsp_err        : response invalid (out of range or flushed)
//   ram_ren        : prime RAM read enable (combinational)
//   ram_address    : prime RAM read index (combinational)
//   ram_q          : prime RAM read data, valid RAM_LATENCY cycles after ram_ren
//   grant_count    : saturating count of grants since reset
module prime_ram_arbiter
  import prime_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ADDR_W      = PRIME_ADDR_W,
  parameter int unsigned DATA_W      = PRIME_DATA_W,
  parameter int unsigned RAM_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       table_valid,
  input  logic [ADDR_W:0]            prime_count,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  output logic [NUM_REQ-1:0]         ack,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_err,
  output logic                       ram_ren,
  output logic [ADDR_W-1:0]          ram_address,
  input  logic [DATA_W-1:0]          ram_q,
  output logic [GRANT_CNT_W-1:0]     grant_count
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [GRANT_CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_REQ-1:0]     arb_req;
  logic [NUM_REQ-1:0]     grant;
  logic                   any_grant;
  logic [PTR_W-1:0]       sel_idx;
  logic [ADDR_W-1:0]      sel_addr;
  logic                   in_range;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [GRANT_CNT_W-1:0] grant_count_q, grant_count_d;
  rsp_tag_t               new_tag;
  rsp_tag_t               tag_q [RAM_LATENCY];
  rsp_tag_t               tag_d [RAM_LATENCY];
  rsp_tag_t               out_tag;
  logic                   unused_tag_id;

  // Requests are only visible to the arbiter while the table is valid and out of reset.
  assign arb_req = (table_valid && reset_n) ? req : '0;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req_i   (arb_req),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  assign any_grant = |grant;

  // Index and address of the granted requester.
  always_comb begin
    sel_idx  = '0;
    sel_addr = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant[i]) begin
        sel_idx  = PTR_W'(i);
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign in_range    = ({1'b0, sel_addr} < prime_count);
  assign ack         = grant;
  assign ram_ren     = any_grant & in_range;
  assign ram_address = ram_ren ? sel_addr : '0;

  // Pointer moves just past the winner; holds when nothing is granted.
  always_comb begin
    ptr_d = ptr_q;
    if (any_grant) begin
      ptr_d = (sel_idx == PTR_W'(NUM_REQ - 1)) ? '0 : sel_idx + PTR_W'(1);
    end
  end

  always_comb begin
    grant_count_d = grant_count_q;
    if (any_grant && (grant_count_q != CNT_MAX)) begin
      grant_count_d = grant_count_q + GRANT_CNT_W'(1);
    end
  end

  // Tag for the read issued this cycle; out-of-range reads still get a tag.
  always_comb begin
    new_tag = '0;
    if (any_grant) begin
      new_tag.valid = 1'b1;
      new_tag.id    = MAX_REQ'(grant);
      new_tag.err   = ~in_range;
    end
  end

  // Tag shift register; while the table is invalid every tag still in flight
  // is poisoned, so its RAM data is never forwarded.
  always_comb begin
    tag_d[0] = new_tag;
    for (int k = 1; k < int'(RAM_LATENCY); k++) begin
      tag_d[k]     = tag_q[k-1];
      tag_d[k].err = tag_q[k-1].err | ~table_valid;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q         <= '0;
      grant_count_q <= '0;
      for (int k = 0; k < int'(RAM_LATENCY); k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      ptr_q         <= ptr_d;
      grant_count_q <= grant_count_d;
      for (int k = 0; k < int'(RAM_LATENCY); k++) begin
        tag_q[k] <= tag_d[k];
      end
    end
  end

  // Last tag stage lines up with ram_q for the same read.
  assign out_tag       = tag_q[RAM_LATENCY-1];
  assign unused_tag_id = ^out_tag.id;
  assign rsp_valid     = out_tag.valid ? out_tag.id[NUM_REQ-1:0] : '0;
  assign rsp_err       = out_tag.valid & out_tag.err;
  assign rsp_data      = (out_tag.valid && !out_tag.err) ? ram_q : '0;
  assign grant_count   = grant_count_q;

endmodule

// File: tb/tb_prime_ram_arbiter.sv
// Bench for prime_ram_arbiter: scenario tasks plus randomized traffic checked
// against a transaction-level model of grants and responses.
module tb_prime_ram_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 8;
  localparam int unsigned DW   = 10;
  localparam int unsigned LAT  = 3;
  localparam int unsigned PCW  = AW + 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              table_valid;
  logic [AW:0]       prime_count;
  logic [NREQ-1:0]   req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              rsp_err;
  logic              ram_ren;
  logic [AW-1:0]     ram_address;
  logic [DW-1:0]     ram_q;
  logic [15:0]       grant_count;

  int n_checks = 0;
  int n_pass   = 0;

  prime_ram_arbiter #(
    .NUM_REQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .RAM_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .table_valid(table_valid), .prime_count(prime_count),
    .req(req), .req_addr(req_addr), .ack(ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .ram_ren(ram_ren), .ram_address(ram_address), .ram_q(ram_q),
    .grant_count(grant_count)
  );

  always #5 clk = ~clk;

  // Prime RAM: read data appears LAT cycles after ram_ren; junk otherwise.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] rq  [LAT];
  always @(posedge clk) begin
    rq[0] <= ram_ren ? mem[ram_address] : DW'($urandom);
    for (int k = 1; k < int'(LAT); k++) rq[k] <= rq[k-1];
  end
  assign ram_q = rq[LAT-1];

  function automatic int load_primes(input int limit);
    int  n;
    bit  is_p;
    n = 0;
    for (int v = 2; v <= limit; v++) begin
      is_p = 1'b1;
      for (int d = 2; d * d <= v; d++) if (v % d == 0) is_p = 1'b0;
      if (is_p) begin mem[n] = DW'(v); n++; end
    end
    for (int i = n; i < 256; i++) mem[i] = DW'($urandom);
    return n;
  endfunction

  // ---------------- reference model ----------------
  typedef struct { int due; int id; bit err; logic [DW-1:0] data; } rec_t;
  typedef struct packed { logic [NREQ-1:0] v; logic err; logic [DW-1:0] data; } exp_rsp_t;

  rec_t pend[$];
  rec_t mr;
  int   cyc    = 0;
  int   ptr_m  = 0;
  int   gcnt_m = 0;
  int   mg;
  logic [AW-1:0] ma;

  function automatic int model_pick();
    int i;
    if (!reset_n || !table_valid) return -1;
    for (int k = 0; k < int'(NREQ); k++) begin
      i = (ptr_m + k) % int'(NREQ);
      if (req[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] e_ack();
    int g;
    g = model_pick();
    return (g >= 0) ? (NREQ'(1) << g) : '0;
  endfunction

  function automatic logic e_ren();
    int g;
    g = model_pick();
    if (g < 0) return 1'b0;
    return {1'b0, req_addr[g*AW +: AW]} < prime_count;
  endfunction

  function automatic exp_rsp_t e_rsp();
    exp_rsp_t r;
    r = '0;
    foreach (pend[i]) if (pend[i].due == cyc) begin
      r.v    = NREQ'(1) << pend[i].id;
      r.err  = pend[i].err;
      r.data = pend[i].err ? '0 : pend[i].data;
    end
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend.delete();
      ptr_m  = 0;
      gcnt_m = 0;
    end else begin
      if (!table_valid) foreach (pend[i]) if (pend[i].due > cyc) pend[i].err = 1'b1;
      mg = model_pick();
      if (mg >= 0) begin
        ma      = req_addr[mg*AW +: AW];
        mr.due  = cyc + int'(LAT);
        mr.id   = mg;
        mr.err  = ({1'b0, ma} >= prime_count);
        mr.data = mem[ma];
        pend.push_back(mr);
        ptr_m = (mg + 1) % int'(NREQ);
        if (gcnt_m < 65535) gcnt_m++;
      end
      while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
      cyc++;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0; table_valid = 1'b1; req = '1; req_addr = '0; prime_count = PCW'(25);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (ack !== '0) $display("FAIL reset ack got=%b exp=0", ack); else n_pass++;
    n_checks++; if (rsp_valid !== '0) $display("FAIL reset rsp_valid got=%b exp=0", rsp_valid); else n_pass++;
    n_checks++; if (rsp_data !== '0) $display("FAIL reset rsp_data got=%0d exp=0", rsp_data); else n_pass++;
    n_checks++; if (rsp_err !== 1'b0) $display("FAIL reset rsp_err got=%b exp=0", rsp_err); else n_pass++;
    n_checks++; if (ram_ren !== 1'b0) $display("FAIL reset ram_ren got=%b exp=0", ram_ren); else n_pass++;
    n_checks++; if (ram_address !== '0) $display("FAIL reset ram_address got=%0d exp=0", ram_address); else n_pass++;
    n_checks++; if (grant_count !== 16'd0) $display("FAIL reset grant_count got=%0d exp=0", grant_count); else n_pass++;
    req = '0;
    next_cycle();
    reset_n = 1'b1;
  endtask

  task automatic test_fairness();
    logic [DW-1:0] seq [4];
    exp_rsp_t er;
    seq[0] = 10'd2; seq[1] = 10'd3; seq[2] = 10'd5; seq[3] = 10'd7;
    prime_count = PCW'(load_primes(100));
    table_valid = 1'b1;
    req_addr = {8'd3, 8'd2, 8'd1, 8'd0};
    req = 4'b1111;
    for (int c = 0; c < 8 + int'(LAT); c++) begin
      @(negedge clk);
      er = e_rsp();
      if (c < 8) begin
        n_checks++; if (ack !== (NREQ'(1) << (c % 4))) $display("FAIL fair ack c=%0d got=%b exp=%b", c, ack, NREQ'(1) << (c % 4)); else n_pass++;
      end
      n_checks++; if (rsp_valid !== er.v) $display("FAIL fair rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, er.v); else n_pass++;
      if (c >= int'(LAT)) begin
        n_checks++; if (rsp_data !== seq[(c - int'(LAT)) % 4]) $display("FAIL fair rsp_data c=%0d got=%0d exp=%0d", c, rsp_data, seq[(c - int'(LAT)) % 4]); else n_pass++;
      end
      next_cycle();
      if (c == 7) req = '0;
    end
    n_checks++; if (grant_count !== 16'd8) $display("FAIL fair grant_count got=%0d exp=8", grant_count); else n_pass++;
  endtask

  task automatic test_single_read();
    exp_rsp_t er;
    req_addr[0 +: AW] = 8'd11;
    req = 4'b0001;
    @(negedge clk);
    n_checks++; if (ack !== 4'b0001) $display("FAIL single ack got=%b exp=0001", ack); else n_pass++;
    n_checks++; if (ram_ren !== 1'b1 || ram_address !== 8'd11) $display("FAIL single ram ren=%b addr=%0d exp ren=1 addr=11", ram_ren, ram_address); else n_pass++;
    next_cycle();
    req = '0;
    for (int k = 1; k <= int'(LAT); k++) begin
      @(negedge clk);
      er = e_rsp();
      n_checks++; if (rsp_valid !== er.v) $display("FAIL single rsp_valid k=%0d got=%b exp=%b", k, rsp_valid, er.v); else n_pass++;
      if (k == int'(LAT)) begin
        n_checks++; if (rsp_data !== 10'd37 || rsp_err !== 1'b0) $display("FAIL single rsp data=%0d err=%b exp data=37 err=0", rsp_data, rsp_err); else n_pass++;
      end
      next_cycle();
    end
  endtask

  task automatic test_out_of_range();
    req_addr[2*AW +: AW] = 8'd25;
    req = 4'b0100;
    @(negedge clk);
    n_checks++; if (ack !== 4'b0100) $display("FAIL oor ack got=%b exp=0100", ack); else n_pass++;
    n_checks++; if (ram_ren !== 1'b0) $display("FAIL oor ram_ren got=%b exp=0", ram_ren); else n_pass++;
    next_cycle();
    req = '0;
    repeat (LAT - 1) begin
      @(negedge clk);
      n_checks++; if (rsp_valid !== '0) $display("FAIL oor early rsp_valid got=%b exp=0", rsp_valid); else n_pass++;
      next_cycle();
    end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 4'b0100 || rsp_err !== 1'b1 || rsp_data !== '0)
      $display("FAIL oor rsp valid=%b err=%b data=%0d exp valid=0100 err=1 data=0", rsp_valid, rsp_err, rsp_data); else n_pass++;
    next_cycle();
  endtask

  task automatic test_gating();
    exp_rsp_t er;
    table_valid = 1'b0;
    req_addr[1*AW +: AW] = 8'd57;
    req = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++; if (ack !== '0 || ram_ren !== 1'b0) $display("FAIL gate c=%0d ack=%b ren=%b exp ack=0 ren=0", c, ack, ram_ren); else n_pass++;
      next_cycle();
      if (c == 2) prime_count = PCW'(load_primes(500));
    end
    table_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (ack !== 4'b0010 || ram_address !== 8'd57) $display("FAIL gate ack=%b addr=%0d exp ack=0010 addr=57", ack, ram_address); else n_pass++;
    next_cycle();
    req = '0;
    repeat (LAT - 1) next_cycle();
    @(negedge clk);
    er = e_rsp();
    n_checks++; if (rsp_valid !== er.v || rsp_data !== 10'd271) $display("FAIL gate rsp valid=%b data=%0d exp valid=%b data=271", rsp_valid, rsp_data, er.v); else n_pass++;
    next_cycle();
  endtask

  task automatic test_flush();
    exp_rsp_t er;
    req_addr[3*AW +: AW] = 8'd10;
    req = 4'b1000;
    @(negedge clk);
    n_checks++; if (ack !== 4'b1000) $display("FAIL flush ack got=%b exp=1000", ack); else n_pass++;
    next_cycle();
    req = '0;
    table_valid = 1'b0;
    repeat (LAT - 1) next_cycle();
    @(negedge clk);
    er = e_rsp();
    n_checks++; if (rsp_valid !== 4'b1000 || rsp_err !== 1'b1 || rsp_data !== '0)
      $display("FAIL flush rsp valid=%b err=%b data=%0d exp valid=1000 err=1 data=0", rsp_valid, rsp_err, rsp_data); else n_pass++;
    n_checks++; if (rsp_err !== er.err) $display("FAIL flush model err got=%b exp=%b", rsp_err, er.err); else n_pass++;
    next_cycle();
    table_valid = 1'b1;
  endtask

  task automatic test_reset_midflight();
    req_addr[1*AW +: AW] = 8'd5;
    req = 4'b0010;
    @(negedge clk);
    n_checks++; if (ack !== 4'b0010) $display("FAIL midrst ack got=%b exp=0010", ack); else n_pass++;
    @(posedge clk);
    req = '0;
    #2 reset_n = 1'b0;
    @(negedge clk);
    n_checks++; if (grant_count !== 16'd0 || ack !== '0 || ram_ren !== 1'b0 || ram_address !== '0)
      $display("FAIL midrst outputs cnt=%0d ack=%b ren=%b addr=%0d exp all 0", grant_count, ack, ram_ren, ram_address); else n_pass++;
    next_cycle();
    reset_n = 1'b1;
    for (int c = 0; c < int'(LAT) + 1; c++) begin
      @(negedge clk);
      n_checks++; if (rsp_valid !== '0 || rsp_err !== 1'b0 || rsp_data !== '0)
        $display("FAIL midrst rsp c=%0d valid=%b err=%b data=%0d exp 0", c, rsp_valid, rsp_err, rsp_data); else n_pass++;
      next_cycle();
    end
    req = 4'b1111;
    @(negedge clk);
    n_checks++; if (ack !== 4'b0001) $display("FAIL midrst pointer ack got=%b exp=0001", ack); else n_pass++;
    next_cycle();
    req = '0;
    repeat (LAT + 1) next_cycle();
  endtask

  task automatic test_random();
    logic [NREQ-1:0] ea;
    logic            er_en;
    exp_rsp_t        er;
    table_valid = 1'b0;
    req = '0;
    prime_count = PCW'(load_primes(500));
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      ea = e_ack(); er_en = e_ren(); er = e_rsp();
      n_checks++; if (ack !== ea) $display("FAIL rand ack c=%0d got=%b exp=%b", c, ack, ea); else n_pass++;
      n_checks++; if (ram_ren !== er_en) $display("FAIL rand ram_ren c=%0d got=%b exp=%b", c, ram_ren, er_en); else n_pass++;
      n_checks++; if (rsp_valid !== er.v) $display("FAIL rand rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, er.v); else n_pass++;
      n_checks++; if (rsp_err !== er.err) $display("FAIL rand rsp_err c=%0d got=%b exp=%b", c, rsp_err, er.err); else n_pass++;
      n_checks++; if (rsp_data !== er.data) $display("FAIL rand rsp_data c=%0d got=%0d exp=%0d", c, rsp_data, er.data); else n_pass++;
      n_checks++; if (grant_count !== 16'(gcnt_m)) $display("FAIL rand grant_count c=%0d got=%0d exp=%0d", c, grant_count, gcnt_m); else n_pass++;
      next_cycle();
      for (int i = 0; i < int'(NREQ); i++) begin
        if (ea[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          else req_addr[i*AW +: AW] = AW'($urandom_range(0, 110));
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          req_addr[i*AW +: AW] = AW'($urandom_range(0, 110));
          req[i] = 1'b1;
        end
      end
      if (table_valid) begin
        if ($urandom_range(0, 19) == 0) table_valid = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        prime_count = ($urandom_range(0, 9) == 0) ? '0 : PCW'($urandom_range(1, 100));
        table_valid = 1'b1;
      end
    end
    req = '0;
    for (int c = 0; c < int'(LAT) + 1; c++) begin
      @(negedge clk);
      er = e_rsp();
      n_checks++; if (rsp_valid !== er.v || rsp_data !== er.data || rsp_err !== er.err)
        $display("FAIL rand drain c=%0d valid=%b data=%0d err=%b exp %b %0d %b", c, rsp_valid, rsp_data, rsp_err, er.v, er.data, er.err); else n_pass++;
      next_cycle();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fairness();
    test_single_read();
    test_out_of_range();
    test_gating();
    test_flush();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
